// File: rtl/aes_inv_round_ctrl_pkg.sv
// Shared definitions for the iterative AES inverse-cipher controller:
// key-length encodings, round counts, FSM states and GF(2^8)/S-box helpers.
package aes_inv_round_ctrl_pkg;

    typedef logic [1:0] key_len_t;

    localparam key_len_t KeyLen128 = 2'd0;
    localparam key_len_t KeyLen192 = 2'd1;
    localparam key_len_t KeyLen256 = 2'd2;

    localparam logic [3:0] Nr128 = 4'd10;
    localparam logic [3:0] Nr192 = 4'd12;
    localparam logic [3:0] Nr256 = 4'd14;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRound = 2'd1,
        StFinal = 2'd2
    } fsm_e;

    // Entry b lives at index 255-b (i.e. ~b) because the first listed byte is the MSB.
    localparam logic [255:0][7:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Encoding 3 selects the 14-round schedule, same as 2.
    function automatic logic [3:0] nr_of(input key_len_t key_len);
        case (key_len)
            KeyLen128: return Nr128;
            KeyLen192: return Nr192;
            KeyLen256: return Nr256;
            default:   return Nr256;
        endcase
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return InvSbox[~b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Request/response and key-store bundle between the decryption top level and
// the inverse-round controller.
interface aes_inv_round_ctrl_if;
    import aes_inv_round_ctrl_pkg::*;

    logic         start;
    key_len_t     key_len;
    logic [127:0] ct_in;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         busy;
    logic         done;
    logic [127:0] pt_out;

    // The requester side also supplies the round key looked up by rk_idx.
    modport master (
        output start, key_len, ct_in, rk,
        input  rk_idx, busy, done, pt_out
    );

    modport slave (
        input  start, key_len, ct_in, rk,
        output rk_idx, busy, done, pt_out
    );

endinterface

// File: rtl/aes_inv_round_ctrl_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless last is set, InvMixColumns. Byte 0 of the state sits at [127:120],
// bytes are column-major (byte index = row + 4*col).
module aes_inv_round_ctrl_inv_round
    import aes_inv_round_ctrl_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] result
);

    logic [127:0] sub;
    logic [127:0] mix;

    // Row r is rotated right by r, so output column c reads input column (c - r) mod 4.
    for (genvar i = 0; i < 16; i++) begin : g_sub
        localparam int unsigned Row = i % 4;
        localparam int unsigned Col = i / 4;
        localparam int unsigned Src = Row + 4 * ((Col + 4 - Row) % 4);
        assign sub[127 - 8*i -: 8] = inv_sbox(state[127 - 8*Src -: 8]) ^ rk[127 - 8*i -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sub[127 - 32*c -: 8];
        assign a1 = sub[119 - 32*c -: 8];
        assign a2 = sub[111 - 32*c -: 8];
        assign a3 = sub[103 - 32*c -: 8];
        assign mix[127 - 32*c -: 8] = gf_mul_e(a0) ^ gf_mul_b(a1) ^ gf_mul_d(a2) ^ gf_mul_9(a3);
        assign mix[119 - 32*c -: 8] = gf_mul_9(a0) ^ gf_mul_e(a1) ^ gf_mul_b(a2) ^ gf_mul_d(a3);
        assign mix[111 - 32*c -: 8] = gf_mul_d(a0) ^ gf_mul_9(a1) ^ gf_mul_e(a2) ^ gf_mul_b(a3);
        assign mix[103 - 32*c -: 8] = gf_mul_b(a0) ^ gf_mul_d(a1) ^ gf_mul_9(a2) ^ gf_mul_e(a3);
    end

    assign result = last ? sub : mix;

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher controller: one inverse round per clock through a
// shared round datapath, round keys fetched from an external store by index.
module aes_inv_round_ctrl
    import aes_inv_round_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    aes_inv_round_ctrl_if.slave     bus
);

    fsm_e         fsm_q;
    logic [3:0]   r_q;
    logic [127:0] state_q;
    logic [127:0] pt_out_q;
    logic         busy_q;
    logic         done_q;

    logic [3:0]   rk_idx;
    logic         last;
    logic [127:0] round_out;

    assign last = (fsm_q == StFinal);

    aes_inv_round_ctrl_inv_round u_round (
        .state  (state_q),
        .rk     (bus.rk),
        .last   (last),
        .result (round_out)
    );

    // Round-key index: Nr of the pending request in IDLE, the counter while running.
    always_comb begin
        rk_idx = 4'd0;
        case (fsm_q)
            StIdle:  rk_idx = nr_of(bus.key_len);
            StRound: rk_idx = r_q;
            StFinal: rk_idx = 4'd0;
            default: rk_idx = 4'd0;
        endcase
    end

    // Controller FSM with the round counter, state register and registered outputs.
    // r_q is loaded with Nr-1 at start and so also holds the frozen round count.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= StIdle;
            r_q      <= 4'd0;
            state_q  <= '0;
            pt_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= bus.ct_in ^ bus.rk;
                        r_q     <= nr_of(bus.key_len) - 4'd1;
                        busy_q  <= 1'b1;
                        fsm_q   <= StRound;
                    end
                end
                StRound: begin
                    state_q <= round_out;
                    if (r_q == 4'd1) begin
                        fsm_q <= StFinal;
                    end else begin
                        r_q <= r_q - 4'd1;
                    end
                end
                StFinal: begin
                    pt_out_q <= round_out;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    fsm_q    <= StIdle;
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

    assign bus.rk_idx = rk_idx;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.pt_out = pt_out_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl using the FIPS-197 appendix C vectors.
// The key store is modelled here with its own forward S-box and key expansion.
module tb_aes_inv_round_ctrl;

    localparam logic [127:0] Pt     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] Ct128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Ct192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] Ct256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] Key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] Key192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                                       64'h0};
    localparam logic [255:0] Key256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    localparam logic [255:0][7:0] Sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk;
    logic         rst;
    logic [127:0] rk_store [16];
    int           n_tests;
    int           n_fail;

    aes_inv_round_ctrl_if bus ();

    aes_inv_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rk = rk_store[bus.rk_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {Sbox[~w[31:24]], Sbox[~w[23:16]], Sbox[~w[15:8]], Sbox[~w[7:0]]};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // FIPS-197 key expansion into the round-key store.
    task automatic load_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = xt(rcon);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int j = 0; j <= nr; j++) begin
            rk_store[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        end
    endtask

    // Issues one request and follows it edge by edge up to the done cycle.
    // poke_at >= 1 pulses start with a different ciphertext before that edge.
    task automatic run_op(input logic [1:0] kl, input logic [127:0] ct, input int nr,
                          input int poke_at);
        bus.key_len = kl;
        bus.ct_in   = ct;
        bus.start   = 1'b1;
        #1;
        check("rk_idx_idle", {124'h0, bus.rk_idx}, nr);
        tick();
        bus.start   = 1'b0;
        bus.key_len = 2'd0;
        bus.ct_in   = '1;
        for (int k = 0; k <= nr; k++) begin
            if (k < nr) begin
                check("busy_run", {127'h0, bus.busy}, 1);
                check("done_early", {127'h0, bus.done}, 0);
                check("rk_idx_run", {124'h0, bus.rk_idx}, nr - 1 - k);
                bus.start = (k + 1 == poke_at);
                if (k + 1 == poke_at) begin
                    bus.ct_in = Ct192;
                end
                tick();
            end else begin
                check("done_pulse", {127'h0, bus.done}, 1);
                check("busy_done", {127'h0, bus.busy}, 0);
                check("pt_out", bus.pt_out, Pt);
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic idle_check(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            tick();
            check("done_idle", {127'h0, bus.done}, 0);
            check("busy_idle", {127'h0, bus.busy}, 0);
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.key_len = 2'd0;
        bus.ct_in   = '0;
        load_key(Key128, 4);
        tick();
        tick();
        check("rst_busy", {127'h0, bus.busy}, 0);
        check("rst_done", {127'h0, bus.done}, 0);
        check("rst_pt_out", bus.pt_out, 0);
        check("rst_rk_idx", {124'h0, bus.rk_idx}, 10);
        rst = 1'b0;
        bus.key_len = 2'd1;
        #1;
        check("idle_rk_idx_192", {124'h0, bus.rk_idx}, 12);
        bus.key_len = 2'd3;
        #1;
        check("idle_rk_idx_kl3", {124'h0, bus.rk_idx}, 14);
        bus.key_len = 2'd0;
        tick();

        run_op(2'd0, Ct128, 10, -1);
        idle_check(3);

        load_key(Key192, 6);
        run_op(2'd1, Ct192, 12, -1);
        idle_check(2);

        load_key(Key256, 8);
        run_op(2'd2, Ct256, 14, -1);
        idle_check(2);
        run_op(2'd3, Ct256, 14, -1);
        idle_check(2);

        // Start while busy must be ignored.
        load_key(Key128, 4);
        run_op(2'd0, Ct128, 10, 5);
        idle_check(3);

        // Back-to-back: second start issued in the first done cycle.
        run_op(2'd0, Ct128, 10, -1);
        run_op(2'd0, Ct128, 10, -1);
        idle_check(2);

        // Reset sampled at edge 6 of an AES-128 run.
        bus.key_len = 2'd0;
        bus.ct_in   = Ct128;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {127'h0, bus.busy}, 0);
        check("midrst_pt_out", bus.pt_out, 0);
        check("midrst_done", {127'h0, bus.done}, 0);
        check("midrst_rk_idx", {124'h0, bus.rk_idx}, 10);
        idle_check(12);
        run_op(2'd0, Ct128, 10, -1);
        idle_check(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
